// File: rtl/object_dma_m.sv
// object_dma_m
//   Copies LENGTH bytes from source memory page {src_page, 8'h00..} into VRAM
//   starting at DST_BASE, one byte at a time, and merges those DMA writes with
//   the CPU VRAM write port. The CPU always wins; DMA writes only land in
//   cycles where the video timing opens the write window and the CPU is idle.
//
// Ports
//   clk, rst          : pixel clock, synchronous active-high reset
//   start             : one-cycle transfer request (honoured only in IDLE)
//   src_page          : source high address byte, latched at start
//   writable          : VRAM write window from video timing
//   cpu_data/address/write_enable : CPU VRAM write request (pass-through)
//   mem_req/addr/ack/rdata        : source memory read handshake
//   data/address/write_enable     : merged VRAM write port to the foreground
//   busy              : high while reading/writing
//   done              : one-cycle completion pulse

module object_dma_m #(
   parameter int unsigned                 VRAM_ADDR_WIDTH = 12,
   parameter logic [VRAM_ADDR_WIDTH-1:0]  DST_BASE        = 12'h800,
   parameter int unsigned                 LENGTH          = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [7:0]                  src_page,
   input  logic                        writable,
   input  logic [7:0]                  cpu_data,
   input  logic [VRAM_ADDR_WIDTH-1:0]  cpu_address,
   input  logic                        cpu_write_enable,
   output logic                        mem_req,
   output logic [15:0]                 mem_addr,
   input  logic                        mem_ack,
   input  logic [7:0]                  mem_rdata,
   output logic [7:0]                  data,
   output logic [VRAM_ADDR_WIDTH-1:0]  address,
   output logic                        write_enable,
   output logic                        busy,
   output logic                        done
);

   localparam logic [7:0] LastIndex = 8'(LENGTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] index_q, index_d;
   logic [7:0] page_q,  page_d;
   logic [7:0] byte_q,  byte_d;
   logic       dma_we;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         index_q <= 8'd0;
         page_q  <= 8'd0;
         byte_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         page_q  <= page_d;
         byte_q  <= byte_d;
      end
   end

   // Next-state and control outputs
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      page_d  = page_q;
      byte_d  = byte_q;
      mem_req = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      dma_we  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               page_d  = src_page;
               index_d = 8'd0;
               state_d = StRead;
            end
         end

         StRead: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ack) begin
               byte_d  = mem_rdata;
               state_d = StWrite;
            end
         end

         StWrite: begin
            busy = 1'b1;
            // The CPU owns the port whenever it writes; DMA waits for a free,
            // writable cycle and holds index/byte until then.
            if (writable && !cpu_write_enable) begin
               dma_we = 1'b1;
               if (index_q == LastIndex) begin
                  state_d = StDone;
               end else begin
                  index_d = index_q + 8'd1;
                  state_d = StRead;
               end
            end
         end

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   assign mem_addr = {page_q, index_q};

   // Merged VRAM write port. CPU pass-through is combinational and not gated
   // by writable or reset; the foreground applies its own window gating.
   always_comb begin
      write_enable = 1'b0;
      data         = byte_q;
      address      = DST_BASE + VRAM_ADDR_WIDTH'(index_q);
      if (cpu_write_enable) begin
         write_enable = 1'b1;
         data         = cpu_data;
         address      = cpu_address;
      end else if (dma_we) begin
         write_enable = 1'b1;
      end
   end

endmodule
